// File: rtl/des_block_sequencer.sv
// Block sequencer wrapping an external DES decrypt core: accepts ciphertext blocks,
// drives the core handshake, applies optional CBC chaining and returns plaintext.
module des_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      cfg_key,
  input  logic [63:0]      cfg_iv,
  input  logic             cfg_cbc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [63:0]      core_message,
  output logic [63:0]      core_key,
  output logic             core_enable,
  output logic             core_ack,
  input  logic             core_done,
  input  logic [63:0]      core_result,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] block_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, ACK, OUTPUT, ERR} state_t;

  state_t            state_reg, state_next;
  logic [63:0]       key_reg, chain_reg, cblk_reg, out_reg;
  logic              cbc_reg, configured_reg, error_reg;
  logic [TW-1:0]     timer_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              accept, start_ok, timeout_hit;

  assign accept      = in_valid && in_ready;
  assign start_ok    = start && (state_reg == IDLE || state_reg == ERR);
  assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  assign out_data     = out_reg;
  assign core_message = cblk_reg;
  assign core_key     = key_reg;
  assign error        = error_reg;
  assign block_count  = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    core_enable = 1'b0;
    core_ack    = 1'b0;
    busy        = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        in_ready = configured_reg && !error_reg;
        if (in_valid && configured_reg && !error_reg) state_next = LOAD;
      end
      LOAD: state_next = WAIT_DONE;
      WAIT_DONE: begin
        core_enable = 1'b1;
        if (core_done)        state_next = ACK;
        else if (timeout_hit) state_next = ERR;
      end
      ACK: begin
        core_ack = 1'b1;
        if (!core_done) state_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      ERR:     if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_reg        <= '0;
      chain_reg      <= '0;
      cblk_reg       <= '0;
      out_reg        <= '0;
      cbc_reg        <= 1'b0;
      configured_reg <= 1'b0;
      error_reg      <= 1'b0;
      timer_reg      <= '0;
      count_reg      <= '0;
    end else begin
      if (start_ok) begin
        key_reg        <= cfg_key;
        cbc_reg        <= cfg_cbc;
        chain_reg      <= cfg_iv;
        configured_reg <= 1'b1;
        error_reg      <= 1'b0;
        count_reg      <= '0;
      end
      if (accept) cblk_reg <= in_data;
      if (state_reg == LOAD)           timer_reg <= '0;
      else if (state_reg == WAIT_DONE) timer_reg <= timer_reg + TW'(1);
      // Chaining value is still the previous ciphertext here; it advances on leaving ACK.
      if (state_reg == WAIT_DONE && core_done)
        out_reg <= core_result ^ (cbc_reg ? chain_reg : 64'd0);
      if (state_reg == WAIT_DONE && !core_done && timeout_hit) error_reg <= 1'b1;
      if (state_reg == ACK && !core_done) chain_reg <= cblk_reg;
      if (state_reg == OUTPUT && out_ready) count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_des_block_sequencer.sv
// Self-checking bench for des_block_sequencer with a behavioural core stand-in,
// directed vector table, randomized chained traffic and timeout/reset corner cases.
module tb_des_block_sequencer;
  localparam int TO = 40;
  localparam int CW = 4;
  localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] C1 = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] C2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C3 = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cfg_cbc = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] cfg_key = '0, cfg_iv = '0, in_data = '0;
  logic in_ready, out_valid, core_enable, core_ack, busy, error, core_done;
  logic [63:0] out_data, core_message, core_key, core_result;
  logic [CW-1:0] block_count;

  int checks = 0, errors = 0;
  int core_lat = 2, core_cnt = 0, hs_viol = 0;
  bit core_hang = 1'b0;
  logic [63:0] last_in = '0;

  logic [63:0] m_key = '0, m_chain = '0;
  bit m_cbc = 1'b0;
  int m_count = 0;

  typedef struct {
    bit do_start; logic [63:0] key; logic [63:0] iv; bit cbc;
    logic [63:0] cdata; int hold; bit poke; logic [63:0] exp_out; int exp_cnt;
  } vec_t;
  vec_t tbl [5];

  des_block_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_cbc(cfg_cbc), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_message(core_message), .core_key(core_key), .core_enable(core_enable),
    .core_ack(core_ack), .core_done(core_done), .core_result(core_result),
    .busy(busy), .error(error), .block_count(block_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the decrypt core: the known DES vector, otherwise an invertible mix.
  function automatic logic [63:0] core_fn(input logic [63:0] m, input logic [63:0] k);
    if (k == K1 && m == C1) return P1;
    return {m[31:0], m[63:32]} ^ k ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_done <= 1'b0; core_result <= '0; core_cnt <= 0;
    end else if (core_done) begin
      if (core_ack) core_done <= 1'b0;
    end else if (core_enable && !core_hang) begin
      if (core_cnt >= core_lat) begin
        core_done <= 1'b1; core_result <= core_fn(core_message, core_key); core_cnt <= 0;
      end else core_cnt <= core_cnt + 1;
    end else core_cnt <= 0;
  end

  always @(posedge clk) if (in_valid && in_ready) last_in <= in_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (core_enable && core_ack) hs_viol <= hs_viol + 1;
      if (busy && !out_valid && !error && core_message !== last_in) hs_viol <= hs_viol + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++; errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic do_start(input logic [63:0] key, input logic [63:0] iv, input bit cbc);
    @(negedge clk);
    cfg_key = key; cfg_iv = iv; cfg_cbc = cbc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_key = key; m_chain = iv; m_cbc = cbc; m_count = 0;
    chk("start_error", {63'd0, error}, 64'd0);
    chk("start_count", 64'(block_count), 64'd0);
  endtask

  task automatic send_block(input logic [63:0] c, input int hold, input bit poke,
                            output logic [63:0] got, output logic [63:0] expd,
                            output int cnt, output bit ok);
    int n;
    logic [63:0] held;
    bit bad;
    ok = 1'b0; got = '0; cnt = 0;
    expd = core_fn(c, m_key) ^ (m_cbc ? m_chain : 64'd0);
    m_chain = c;
    @(negedge clk);
    in_valid = 1'b1; in_data = c;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin fail_bound("in_ready_wait"); in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) begin fail_bound("out_valid_wait"); return; end
    held = out_data; bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 5) begin
        cfg_key = {$urandom, $urandom}; cfg_iv = {$urandom, $urandom};
        cfg_cbc = ~m_cbc; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      if (!out_valid || out_data !== held || in_ready || core_enable) bad = 1'b1;
    end
    start = 1'b0;
    if (hold > 0) chk("backpressure_stable", {63'd0, bad}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_count = (m_count + 1) % (1 << CW);
    got = held; cnt = int'(block_count); ok = 1'b1;
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    $display("blk c=%h out=%h count=%0d", c, got, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got, expd;
    int cnt, n;
    bit ok, ov_seen;

    tbl[0] = '{1'b1, K1, 64'd0, 1'b0, C1, 0,  1'b0, P1, 1};
    tbl[1] = '{1'b1, K1, 64'd1, 1'b1, C1, 0,  1'b0, P1 ^ 64'd1, 1};
    tbl[2] = '{1'b0, K1, 64'd0, 1'b0, C2, 20, 1'b1, core_fn(C2, K1) ^ C1, 2};
    tbl[3] = '{1'b0, K1, 64'd0, 1'b0, C3, 0,  1'b0, core_fn(C3, K1) ^ C2, 3};
    tbl[4] = '{1'b1, K1, 64'd1, 1'b1, C1, 2,  1'b0, P1 ^ 64'd1, 1};

    // Reset state
    @(negedge clk);
    chk("reset_ctl", 64'({in_ready, out_valid, core_enable, core_ack, busy, error}), 64'd0);
    chk("reset_count", 64'(block_count), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_core_bus", core_message | core_key, 64'd0);
    reset = 1'b0;
    in_valid = 1'b1; in_data = C1;
    repeat (3) @(negedge clk);
    chk("unconfigured_in_ready", 64'({in_ready, busy}), 64'd0);
    in_valid = 1'b0;

    // Directed vectors: ECB, CBC chain with back-pressure and ignored start, restart
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].do_start) do_start(tbl[i].key, tbl[i].iv, tbl[i].cbc);
      send_block(tbl[i].cdata, tbl[i].hold, tbl[i].poke, got, expd, cnt, ok);
      if (ok) begin
        chk($sformatf("vec%0d_data", i), got, tbl[i].exp_out);
        chk($sformatf("vec%0d_count", i), 64'(cnt), 64'(tbl[i].exp_cnt));
      end
    end

    // Randomized traffic across a block_count wrap
    do_start({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) begin
      core_lat = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("idle_out_ready", 64'({out_valid, block_count}), 64'(m_count));
      end
      send_block({$urandom, $urandom}, $urandom_range(0, 3), 1'b0, got, expd, cnt, ok);
      if (ok) begin
        chk($sformatf("rnd%0d_data", i), got, expd);
        chk($sformatf("rnd%0d_count", i), 64'(cnt), 64'(m_count));
      end
    end

    // Timeout: core never completes
    core_hang = 1'b1;
    do_start(K1, 64'd0, 1'b0);
    @(negedge clk); in_valid = 1'b1; in_data = C1;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (!core_enable && n < 20) begin @(negedge clk); n++; end
    if (!core_enable) fail_bound("core_enable_wait");
    else begin
      n = 0;
      while (!error && n < TO + 10) begin @(negedge clk); n++; end
      chk("timeout_cycles", 64'(n), 64'(TO));
      chk("timeout_outputs", 64'({core_enable, in_ready, out_valid, busy}), 64'b0001);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("err_in_ready", 64'({in_ready, error}), 64'b01);
      in_valid = 1'b0;
    end
    core_hang = 1'b0;
    core_lat = 2;
    do_start(K1, 64'd0, 1'b0);
    chk("recovered_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset while the core is working
    core_lat = 10;
    @(negedge clk); in_valid = 1'b1; in_data = C2;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (!core_enable && n < 20) begin @(negedge clk); n++; end
    if (!core_enable) fail_bound("core_enable_wait2");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_ctl", 64'({in_ready, out_valid, core_enable, core_ack, busy, error}), 64'd0);
    chk("midreset_data", out_data | core_message | core_key | 64'(block_count), 64'd0);
    ov_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (out_valid) ov_seen = 1'b1; end
    reset = 1'b0;
    repeat (4) begin @(negedge clk); if (out_valid || in_ready) ov_seen = 1'b1; end
    chk("midreset_no_beat", {63'd0, ov_seen}, 64'd0);
    core_lat = 2;
    do_start(K1, 64'd0, 1'b0);
    send_block(C1, 0, 1'b0, got, expd, cnt, ok);
    if (ok) begin
      chk("post_reset_data", got, P1);
      chk("post_reset_count", 64'(cnt), 64'd1);
    end

    repeat (2) @(negedge clk);
    chk("handshake", 64'(hs_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
